fb_frame_scheduler: RTL and testbench
=====================================

// Module: fb_frame_scheduler
// PURPOSE
//   Owns the single framebuffer write port and sequences each video frame: on frame_pulse it
//   sweeps the whole 1-bpp framebuffer to 0 (CLEAR), then grants the port to the sample_to_pixel
//   plotter (DRAW) until SCREEN_WIDTH columns are plotted, then holds until the next frame.
//   Sits between sample_to_pixel and framebuffer; gates plotter FIFO consumption via plot_enable.
// PARAMETERS
//   SCREEN_WIDTH   640                         columns per frame (one plotted sample per column)
//   SCREEN_HEIGHT  480                         rows per frame
//   NPIX           SCREEN_WIDTH*SCREEN_HEIGHT  framebuffer depth (localparam)
//   ADDR_WIDTH     $clog2(NPIX)                framebuffer address width (19 at defaults)
// PORTS
//   clk             in   1           single clock; all logic on posedge
//   resetn          in   1           reset, synchronous, active-low
//   frame_pulse     in   1           one-cycle start-of-frame strobe
//   plot_wr_en      in   1           plotter write request
//   plot_addr       in   ADDR_WIDTH  plotter write address
//   plot_data       in   1           plotter pixel value
//   plot_col_done   in   1           one-cycle pulse: plotter finished one column/sample
//   plot_enable     out  1           plotter may pop FIFO and write (high only in DRAW)
//   fb_wr_en        out  1           framebuffer write enable (registered)
//   fb_wr_addr      out  ADDR_WIDTH  framebuffer write address (registered)
//   fb_wr_data      out  1           framebuffer write data (registered)
//   state           out  2           IDLE=0, CLEAR=1, DRAW=2, HOLD=3
//   frame_count     out  16          completed frames (DRAW->HOLD transitions), wraps at 2^16
//   overrun         out  1           sticky: frame_pulse arrived before the frame finished
//   dropped_write   out  1           sticky: plot_wr_en seen outside DRAW
// BEHAVIOUR
//   Reset (resetn=0 at posedge): state=IDLE; all outputs, clr_addr, col_cnt, stickies = 0.
//     Applies mid-CLEAR/DRAW too: fb_wr_en=0 next cycle, no partial-cycle writes.
//   IDLE : plot_enable=0, fb_wr_en=0. frame_pulse -> CLEAR, clr_addr=0.
//   CLEAR: each cycle registers fb_wr_en=1, fb_wr_addr=clr_addr, fb_wr_data=0; clr_addr++.
//     Cycle issuing addr NPIX-1 -> DRAW, col_cnt=0. Exactly NPIX writes, addresses 0..NPIX-1
//     ascending, no gaps. frame_pulse during CLEAR: ignored, overrun<=1; sweep continues.
//   DRAW : plot_enable=1 (registered, asserted the cycle after entering DRAW).
//     fb_wr_* <= plot_wr_en/plot_addr/plot_data: 1-cycle latency, no backpressure, never dropped.
//     plot_col_done: col_cnt++. Done while col_cnt==SCREEN_WIDTH-1 -> HOLD, frame_count++.
//     Plot write in that same final cycle is still forwarded.
//     frame_pulse in DRAW (before final done): abort -> CLEAR, clr_addr=0, overrun<=1,
//     frame_count unchanged. Simultaneous with final done: frame completes (frame_count++),
//     goes straight to CLEAR, overrun NOT set.
//   HOLD : plot_enable=0, fb_wr_en=0. frame_pulse -> CLEAR.
//   plot_wr_en outside DRAW (incl. the cycle plot_enable falls): write dropped, dropped_write<=1.
//   plot_col_done outside DRAW: ignored. plot_addr >= NPIX in DRAW: forwarded unchanged
//     (plotter guarantees range).
//   Widths: clr_addr ADDR_WIDTH bits, compared to NPIX-1 (no reliance on 2^n wrap);
//     col_cnt $clog2(SCREEN_WIDTH) bits; frame_count wraps 16'hFFFF->0.
//   Stickies clear only on reset.
// STRUCTURE
//   fb_pkg: SCREEN_WIDTH/HEIGHT defaults, NPIX, ADDR_WIDTH, state encoding localparams.
//   Sub-module fb_clear_engine: start pulse in; address counter out; wr_en, last flag.
//   Top holds the FSM, column counter, write-port mux/register, status.
// TESTING (W=8, H=4 -> NPIX=32, ADDR_WIDTH=5 unless noted)
//   Reset then frame_pulse -> state=CLEAR next cycle; 32 writes, data 0, addr 0..31; then DRAW.
//   DRAW: 8 plot_col_done pulses with writes to addr 3,11,19 -> all forwarded 1 cycle later;
//     HOLD; frame_count=1; plot_enable=0.
//   frame_pulse after 5 columns -> CLEAR, overrun=1, frame_count=0; 32-write sweep restarts at 0.
//   Final plot_col_done and frame_pulse same cycle -> frame_count=1, state=CLEAR, overrun=0.
//   plot_wr_en=1 in CLEAR and HOLD -> no fb_wr from plotter, dropped_write=1.
//   resetn=0 mid-CLEAR at clr_addr=17 -> IDLE, fb_wr_en=0, stickies 0; full-size 640x480
//     run: 307200-write clear.

Source files
------------

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared defaults, state encoding and width helper for the frame scheduler
package fb_pkg;

    localparam int FB_SCREEN_WIDTH  = 640;
    localparam int FB_SCREEN_HEIGHT = 480;
    localparam int FB_NPIX          = FB_SCREEN_WIDTH * FB_SCREEN_HEIGHT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DRAW  = 2'd2,
        ST_HOLD  = 2'd3
    } fb_state_e;

    function automatic int fb_width_for(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/fb_clear_engine.sv
// rtl/fb_clear_engine.sv - ascending address sweep 0..NPIX-1, one write per cycle after start
module fb_clear_engine
    import fb_pkg::*;
#(
    parameter int NPIX       = FB_NPIX,
    parameter int ADDR_WIDTH = fb_width_for(NPIX)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start_i,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);

    // Explicit compare against the final address so non-power-of-two depths stop exactly.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);

    logic                  busy_q, busy_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    assign wr_en_o = busy_q;
    assign addr_o  = addr_q;
    assign last_o  = busy_q && (addr_q == LAST_ADDR);

    always_comb begin
        busy_d = busy_q;
        addr_d = addr_q;
        if (start_i) begin
            busy_d = 1'b1;
            addr_d = '0;
        end else if (busy_q) begin
            if (last_o) begin
                busy_d = 1'b0;
                addr_d = '0;
            end else begin
                addr_d = addr_q + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy_q <= 1'b0;
            addr_q <= '0;
        end else begin
            busy_q <= busy_d;
            addr_q <= addr_d;
        end
    end

endmodule

// File: rtl/fb_frame_scheduler.sv
// rtl/fb_frame_scheduler.sv - framebuffer write-port owner: per-frame clear sweep, then plotter draw
module fb_frame_scheduler
    import fb_pkg::*;
#(
    parameter  int SCREEN_WIDTH  = FB_SCREEN_WIDTH,
    parameter  int SCREEN_HEIGHT = FB_SCREEN_HEIGHT,
    localparam int NPIX          = SCREEN_WIDTH * SCREEN_HEIGHT,
    localparam int ADDR_WIDTH    = fb_width_for(NPIX)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  frame_pulse,
    input  logic                  plot_wr_en,
    input  logic [ADDR_WIDTH-1:0] plot_addr,
    input  logic                  plot_data,
    input  logic                  plot_col_done,
    output logic                  plot_enable,
    output logic                  fb_wr_en,
    output logic [ADDR_WIDTH-1:0] fb_wr_addr,
    output logic                  fb_wr_data,
    output logic [1:0]            state,
    output logic [15:0]           frame_count,
    output logic                  overrun,
    output logic                  dropped_write
);

    localparam int               COL_W    = fb_width_for(SCREEN_WIDTH);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(SCREEN_WIDTH - 1);

    fb_state_e             state_q;
    logic [COL_W-1:0]      col_cnt_q;
    logic [15:0]           frame_count_q;
    logic                  overrun_q;
    logic                  dropped_q;
    logic                  plot_enable_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic                  wr_data_q;

    logic                  clr_start;
    logic                  clr_wr_en;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  clr_last;
    logic                  final_col;

    // Every non-CLEAR state answers frame_pulse by starting a fresh sweep.
    assign clr_start = frame_pulse && (state_q != ST_CLEAR);
    assign final_col = plot_col_done && (col_cnt_q == LAST_COL);

    fb_clear_engine #(
        .NPIX       (NPIX),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear (
        .clk     (clk),
        .resetn  (resetn),
        .start_i (clr_start),
        .wr_en_o (clr_wr_en),
        .addr_o  (clr_addr),
        .last_o  (clr_last)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            col_cnt_q     <= '0;
            frame_count_q <= '0;
            overrun_q     <= 1'b0;
            dropped_q     <= 1'b0;
            plot_enable_q <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= 1'b0;
        end else begin
            wr_en_q       <= 1'b0;
            plot_enable_q <= 1'b0;
            if (plot_wr_en && (state_q != ST_DRAW)) begin
                dropped_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (frame_pulse) state_q <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    wr_en_q   <= clr_wr_en;
                    wr_addr_q <= clr_addr;
                    wr_data_q <= 1'b0;
                    if (frame_pulse) overrun_q <= 1'b1;
                    if (clr_last) begin
                        state_q   <= ST_DRAW;
                        col_cnt_q <= '0;
                    end
                end
                ST_DRAW: begin
                    wr_en_q   <= plot_wr_en;
                    wr_addr_q <= plot_addr;
                    wr_data_q <= plot_data;
                    if (final_col) frame_count_q <= frame_count_q + 16'd1;
                    // A pulse coinciding with the last column completes the frame cleanly.
                    if (frame_pulse) begin
                        state_q <= ST_CLEAR;
                        if (!final_col) overrun_q <= 1'b1;
                    end else if (final_col) begin
                        state_q <= ST_HOLD;
                    end else begin
                        plot_enable_q <= 1'b1;
                        if (plot_col_done) col_cnt_q <= col_cnt_q + COL_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (frame_pulse) state_q <= ST_CLEAR;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign plot_enable   = plot_enable_q;
    assign fb_wr_en      = wr_en_q;
    assign fb_wr_addr    = wr_addr_q;
    assign fb_wr_data    = wr_data_q;
    assign state         = state_q;
    assign frame_count   = frame_count_q;
    assign overrun       = overrun_q;
    assign dropped_write = dropped_q;

endmodule

// File: tb/tb_fb_frame_scheduler.sv
// tb/tb_fb_frame_scheduler.sv - directed and random stimulus against a frame-level reference model
module tb_fb_frame_scheduler;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int AW   = 5;

    logic          clk = 1'b0;
    logic          resetn;
    logic          frame_pulse;
    logic          plot_wr_en;
    logic [AW-1:0] plot_addr;
    logic          plot_data;
    logic          plot_col_done;
    logic          plot_enable;
    logic          fb_wr_en;
    logic [AW-1:0] fb_wr_addr;
    logic          fb_wr_data;
    logic [1:0]    state;
    logic [15:0]   frame_count;
    logic          overrun;
    logic          dropped_write;

    always #5 clk = ~clk;

    fb_frame_scheduler #(
        .SCREEN_WIDTH  (W),
        .SCREEN_HEIGHT (H)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .frame_pulse   (frame_pulse),
        .plot_wr_en    (plot_wr_en),
        .plot_addr     (plot_addr),
        .plot_data     (plot_data),
        .plot_col_done (plot_col_done),
        .plot_enable   (plot_enable),
        .fb_wr_en      (fb_wr_en),
        .fb_wr_addr    (fb_wr_addr),
        .fb_wr_data    (fb_wr_data),
        .state         (state),
        .frame_count   (frame_count),
        .overrun       (overrun),
        .dropped_write (dropped_write)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: frame phase plus countdowns of sweep writes and columns still owed.
    int m_phase, m_clear_left, m_cols_left, m_fc;
    bit m_ovr, m_drop, m_pe, m_wen, m_wdata;
    int m_waddr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit fp, input bit we, input logic [AW-1:0] wa,
                              input bit wd, input bit cd, input bit rst);
        bit fin;
        if (rst) begin
            m_phase = 0; m_clear_left = 0; m_cols_left = 0; m_fc = 0;
            m_ovr = 0; m_drop = 0; m_pe = 0; m_wen = 0; m_waddr = 0; m_wdata = 0;
            return;
        end
        m_wen = 0;
        m_pe  = 0;
        if (we && m_phase != 2) m_drop = 1;
        case (m_phase)
            0, 3: if (fp) begin m_phase = 1; m_clear_left = NPIX; end
            1: begin
                m_wen   = 1;
                m_waddr = NPIX - m_clear_left;
                m_wdata = 0;
                if (fp) m_ovr = 1;
                m_clear_left--;
                if (m_clear_left == 0) begin m_phase = 2; m_cols_left = W; end
            end
            default: begin
                m_wen = we; m_waddr = int'(wa); m_wdata = wd;
                fin = cd && (m_cols_left == 1);
                if (fin) m_fc = (m_fc + 1) % 65536;
                if (fp) begin
                    m_phase = 1; m_clear_left = NPIX;
                    if (!fin) m_ovr = 1;
                end else if (fin) begin
                    m_phase = 3;
                end else begin
                    m_pe = 1;
                    if (cd) m_cols_left--;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check("state", 32'(state), 32'(m_phase));
        check("plot_enable", 32'(plot_enable), 32'(m_pe));
        check("fb_wr_en", 32'(fb_wr_en), 32'(m_wen));
        if (m_wen) begin
            check("fb_wr_addr", 32'(fb_wr_addr), 32'(m_waddr));
            check("fb_wr_data", 32'(fb_wr_data), 32'(m_wdata));
        end
        check("frame_count", 32'(frame_count), 32'(m_fc));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("dropped_write", 32'(dropped_write), 32'(m_drop));
    endtask

    task automatic cyc(input bit fp, input bit we, input logic [AW-1:0] wa,
                       input bit wd, input bit cd, input bit rst);
        compare_all();
        frame_pulse   = fp;
        plot_wr_en    = we;
        plot_addr     = wa;
        plot_data     = wd;
        plot_col_done = cd;
        resetn        = !rst;
        model_step(fp, we, wa, wd, cd, rst);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, 0, 0);
    endtask

    logic [AW-1:0] draw_addr [3];

    initial begin
        draw_addr[0] = 5'd3; draw_addr[1] = 5'd11; draw_addr[2] = 5'd19;
        resetn = 0; frame_pulse = 0; plot_wr_en = 0; plot_addr = '0;
        plot_data = 0; plot_col_done = 0;
        @(posedge clk);
        @(negedge clk);
        model_step(0, 0, '0, 0, 0, 1);
        cyc(0, 0, '0, 0, 0, 1);
        check("reset_state", 32'(state), 32'd0);

        // Full frame: sweep, eight columns with three forwarded writes, then HOLD.
        cyc(1, 0, '0, 0, 0, 0);
        check("clear_entered", 32'(state), 32'd1);
        idle(33);
        for (int c = 0; c < W; c++) cyc(0, c < 3, (c < 3) ? draw_addr[c] : '0, 1, 1, 0);
        idle(2);
        check("frame_done_fc", 32'(frame_count), 32'd1);
        check("frame_done_state", 32'(state), 32'd3);
        check("frame_done_pe", 32'(plot_enable), 32'd0);
        cyc(0, 1, 5'd7, 1, 0, 0);
        check("drop_in_hold", 32'(dropped_write), 32'd1);

        // Abort after five columns, with a stray plot write during the sweep.
        cyc(0, 0, '0, 0, 0, 1);
        cyc(1, 0, '0, 0, 0, 0);
        idle(10);
        cyc(0, 1, 5'd9, 1, 0, 0);
        idle(22);
        for (int c = 0; c < 5; c++) cyc(0, 0, '0, 0, 1, 0);
        cyc(1, 0, '0, 0, 0, 0);
        check("abort_state", 32'(state), 32'd1);
        check("abort_overrun", 32'(overrun), 32'd1);
        check("abort_fc", 32'(frame_count), 32'd0);
        check("drop_in_clear", 32'(dropped_write), 32'd1);
        idle(34);

        // Final column and frame pulse together.
        cyc(0, 0, '0, 0, 0, 1);
        cyc(1, 0, '0, 0, 0, 0);
        idle(33);
        for (int c = 0; c < W - 1; c++) cyc(0, 0, '0, 0, 1, 0);
        cyc(1, 1, 5'd30, 1, 1, 0);
        check("simul_fc", 32'(frame_count), 32'd1);
        check("simul_state", 32'(state), 32'd1);
        check("simul_overrun", 32'(overrun), 32'd0);

        // Reset in the middle of the sweep.
        cyc(1, 0, '0, 0, 0, 1);
        cyc(1, 0, '0, 0, 0, 0);
        idle(17);
        cyc(1, 0, '0, 0, 0, 1);
        check("midclr_state", 32'(state), 32'd0);
        check("midclr_wr_en", 32'(fb_wr_en), 32'd0);
        check("midclr_overrun", 32'(overrun), 32'd0);
        check("midclr_dropped", 32'(dropped_write), 32'd0);

        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom % 60) == 0, ($urandom % 3) == 0, AW'($urandom),
                $urandom % 2 == 1, ($urandom % 3) == 0, ($urandom % 500) == 0);
        end
        compare_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
